mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data load/store share one
// memory port. One transaction in flight at a time; all outputs registered.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of
// always favouring data.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  // Instruction fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  // Data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  // Memory port
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  typedef enum logic [1:0] {StIdle, StIAcc, StDAcc, StResp} state_e;

  state_e      state_q;
  logic        m_req_q;
  logic        m_we_q;
  logic [3:0]  m_wstrb_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        i_ack_q;
  logic        d_ack_q;
  logic        data_wins;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 when the most recent grant went to the data side
  logic last_d_q;

  // Data wins contention only if instruction was granted last
  always_comb begin
    data_wins = d_req & (~i_req | ~last_d_q);
  end

  // Remember which side received the most recent grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else if (state_q == StIdle && (i_req || d_req)) begin
      last_d_q <= data_wins;
    end
  end
`else
  // Fixed priority: data always wins contention
  always_comb begin
    data_wins = d_req;
  end
`endif

  // Arbitration FSM; every output is a register updated here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_wstrb_q <= 4'b0000;
      m_addr_q  <= 32'h0;
      m_wdata_q <= 32'h0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (data_wins) begin
            m_req_q   <= 1'b1;
            m_we_q    <= d_we;
            m_wstrb_q <= d_we ? d_wstrb : 4'b0000;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            state_q   <= StDAcc;
          end else if (i_req) begin
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_wstrb_q <= 4'b0000;
            m_addr_q  <= i_addr;
            m_wdata_q <= 32'h0;
            state_q   <= StIAcc;
          end
        end
        StIAcc: begin
          if (m_ack) begin
            m_req_q   <= 1'b0;
            i_rdata_q <= m_rdata;
            i_ack_q   <= 1'b1;
            state_q   <= StResp;
          end
        end
        StDAcc: begin
          if (m_ack) begin
            m_req_q <= 1'b0;
            // Stores leave the load data register untouched
            if (!m_we_q) begin
              d_rdata_q <= m_rdata;
            end
            d_ack_q <= 1'b1;
            state_q <= StResp;
          end
        end
        StResp: begin
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_wstrb = m_wstrb_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change and outputs are sampled
// 1ns after each rising edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  int checks   = 0;
  int failures = 0;

  mem_arbiter u_dut (
    .clk    (clk),
    .rst    (rst),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_rdata(i_rdata),
    .i_ack  (i_ack),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_wstrb(d_wstrb),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ack  (d_ack),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_wstrb(m_wstrb),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ack  (m_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int cycles;
  int n;
  logic got_d;
  logic exp_d;

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_wstrb = 0;
    d_addr = 0; d_wdata = 0; m_rdata = 0; m_ack = 0;
    step(); step();
    check_eq("rst_m_req", {31'b0, m_req}, 32'd0);
    check_eq("rst_m_addr", m_addr, 32'h0);
    check_eq("rst_acks", {30'b0, i_ack, d_ack}, 32'd0);
    check_eq("rst_rdata", i_rdata | d_rdata, 32'h0);
    rst = 1'b0;
    step();

    // Fetch, zero wait-states
    i_req = 1; i_addr = 32'h1FC00000; m_rdata = 32'h3C1D0001; m_ack = 1;
    check_eq("fetch_c0_m_req", {31'b0, m_req}, 32'd0);
    step();
    check_eq("fetch_c1_m_req", {31'b0, m_req}, 32'd1);
    check_eq("fetch_m_addr", m_addr, 32'h1FC00000);
    check_eq("fetch_m_we", {31'b0, m_we}, 32'd0);
    check_eq("fetch_m_wstrb", {28'b0, m_wstrb}, 32'd0);
    step();
    i_req = 0; m_ack = 0;
    check_eq("fetch_c2_i_ack", {31'b0, i_ack}, 32'd1);
    check_eq("fetch_c2_d_ack", {31'b0, d_ack}, 32'd0);
    check_eq("fetch_i_rdata", i_rdata, 32'h3C1D0001);
    check_eq("fetch_c2_m_req", {31'b0, m_req}, 32'd0);
    step();
    check_eq("fetch_c3_i_ack", {31'b0, i_ack}, 32'd0);

    // Store with 4 wait-states; requester fields change mid-access
    d_req = 1; d_we = 1; d_wstrb = 4'b0011; d_addr = 32'h100; d_wdata = 32'hCAFEF00D;
    step();
    d_addr = 32'hFFFF0000; d_wdata = 32'h0; d_wstrb = 4'b1100; d_we = 0;
    cycles = 0;
    while (m_req && cycles < 20) begin
      cycles++;
      check_eq("st_m_addr", m_addr, 32'h100);
      check_eq("st_m_wdata", m_wdata, 32'hCAFEF00D);
      check_eq("st_m_we_wstrb", {27'b0, m_we, m_wstrb}, {27'b0, 1'b1, 4'b0011});
      check_eq("st_no_ack", {30'b0, i_ack, d_ack}, 32'd0);
      if (cycles == 5) begin
        m_ack = 1; m_rdata = 32'hDEADBEEF;
      end
      step();
    end
    check_eq("st_m_req_cycles", cycles, 32'd5);
    check_eq("st_d_ack", {31'b0, d_ack}, 32'd1);
    check_eq("st_d_rdata_kept", d_rdata, 32'h0);
    d_req = 0; m_ack = 0;
    step();
    check_eq("st_d_ack_clear", {31'b0, d_ack}, 32'd0);

    // Load, zero wait-states; wstrb input must not leak onto the bus
    d_req = 1; d_we = 0; d_wstrb = 4'hF; d_addr = 32'h200; m_rdata = 32'h12345678; m_ack = 1;
    step();
    check_eq("ld_m_addr", m_addr, 32'h200);
    check_eq("ld_m_we_wstrb", {27'b0, m_we, m_wstrb}, 32'd0);
    step();
    d_req = 0; m_ack = 0;
    check_eq("ld_d_ack", {31'b0, d_ack}, 32'd1);
    check_eq("ld_d_rdata", d_rdata, 32'h12345678);
    step();

    // Stray m_ack while idle
    m_ack = 1; m_rdata = 32'hFFFFFFFF;
    step(); step(); step();
    check_eq("idle_m_req", {31'b0, m_req}, 32'd0);
    check_eq("idle_acks", {30'b0, i_ack, d_ack}, 32'd0);
    check_eq("idle_i_rdata", i_rdata, 32'h3C1D0001);
    check_eq("idle_d_rdata", d_rdata, 32'h12345678);
    m_ack = 0;

    // Reset mid data access
    d_req = 1; d_we = 0; d_addr = 32'h300;
    step();
    check_eq("rstacc_m_req_pre", {31'b0, m_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rstacc_m_req_async", {31'b0, m_req}, 32'd0);
    check_eq("rstacc_d_ack", {31'b0, d_ack}, 32'd0);
    check_eq("rstacc_m_addr", m_addr, 32'h0);
    d_req = 0;
    step();
    rst = 1'b0;
    step();
    check_eq("rstacc_idle_m_req", {31'b0, m_req}, 32'd0);
    check_eq("rstacc_idle_d_ack", {31'b0, d_ack}, 32'd0);

    // Contention with both requests held continuously
    i_req = 1; i_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h500;
    m_ack = 1; m_rdata = 32'h0BADF00D;
    n = 0; cycles = 0;
    while (n < 4 && cycles < 40) begin
      step();
      cycles++;
      check_eq("cont_ack_excl", {31'b0, i_ack & d_ack}, 32'd0);
      if (i_ack || d_ack) begin
        got_d = d_ack;
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = (n % 2 == 0);
`else
        exp_d = 1'b1;
`endif
        check_eq($sformatf("cont_grant%0d_is_data", n), {31'b0, got_d}, {31'b0, exp_d});
        n++;
      end
    end
    check_eq("cont_grant_count", n, 32'd4);
    i_req = 0; d_req = 0; m_ack = 0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
